// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues word reads to
// instruction memory and loads the IF/ID pipeline register for decode.
// A one-word skid register catches data that arrives while decode stalls,
// so the stalled word is delivered on release without re-reading memory.
module instruction_fetch (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchTarget,
    input  logic        Stall_PC,
    input  logic        Flush,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlusFour,
    output logic        Valid,
    output logic [31:0] PC
);

    // FETCH: request outstanding at PC. HOLD: word parked in skid, no request.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    // Sequential PC increment wraps naturally at 2^32; redirects are word aligned.
    assign pc_inc         = pc_q + 32'd4;
    assign target_aligned = BranchTarget & 32'hFFFF_FFFC;

    // Memory request is decoded from state; address always tracks the PC.
    assign IMem_Req    = (state_q == FETCH);
    assign IMem_Addr   = pc_q;

    assign Instruction = instr_q;
    assign PCPlusFour  = pc_plus4_q;
    assign Valid       = valid_q;
    assign PC          = pc_q;

    // Next-state and IF/ID load decisions; every register holds by default.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        skid_d     = skid_q;

        if (PCSel) begin
            // Redirect wins over stall and memory handshake; any parked or
            // pending word belongs to the old path and is dropped.
            pc_d    = target_aligned;
            valid_d = 1'b0;
            instr_d = 32'h0000_0000;
            skid_d  = 32'h0000_0000;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!Stall_PC) begin
                        if (IMem_Ready) begin
                            instr_d    = IMem_Data;
                            pc_plus4_d = pc_inc;
                            valid_d    = 1'b1;
                            pc_d       = pc_inc;
                        end else begin
                            // Memory wait: emit a bubble, keep asking for PC.
                            valid_d = 1'b0;
                            instr_d = 32'h0000_0000;
                        end
                    end else if (IMem_Ready) begin
                        // Decode is stalled but the word arrived: park it.
                        skid_d  = IMem_Data;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!Stall_PC) begin
                        instr_d    = skid_q;
                        pc_plus4_d = pc_inc;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase

            // Flush turns whatever IF/ID would hold into a bubble; the PC and
            // state still move as computed, so a fetched word is simply lost.
            if (Flush) begin
                valid_d    = 1'b0;
                instr_d    = 32'h0000_0000;
                pc_plus4_d = pc_plus4_q;
            end
        end
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= FETCH;
            pc_q       <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            skid_q     <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory returns addr + offset so
// every fetched word identifies the address it came from.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        PCSel;
    logic [31:0] BranchTarget;
    logic        Stall_PC;
    logic        Flush;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_Data;
    logic [31:0] Instruction;
    logic [31:0] PCPlusFour;
    logic        Valid;
    logic [31:0] PC;

    logic [31:0] mem_off;
    int          total = 0;
    int          bad   = 0;

    assign IMem_Data = IMem_Addr + mem_off;

    instruction_fetch dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .PCSel        (PCSel),
        .BranchTarget (BranchTarget),
        .Stall_PC     (Stall_PC),
        .Flush        (Flush),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IMem_Ready   (IMem_Ready),
        .IMem_Data    (IMem_Data),
        .Instruction  (Instruction),
        .PCPlusFour   (PCPlusFour),
        .Valid        (Valid),
        .PC           (PC)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the IF/ID register, PC and request outputs in one go.
    task automatic chk_all(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pcp4,
                           input logic e_valid, input logic [31:0] e_pc, input logic e_req);
        chk({tag, ".instr"}, Instruction, e_instr);
        chk({tag, ".pcp4"},  PCPlusFour,  e_pcp4);
        chk({tag, ".valid"}, {31'd0, Valid}, {31'd0, e_valid});
        chk({tag, ".pc"},    PC,          e_pc);
        chk({tag, ".addr"},  IMem_Addr,   e_pc);
        chk({tag, ".req"},   {31'd0, IMem_Req}, {31'd0, e_req});
        $display("step %-12s pc=%h instr=%h pcp4=%h valid=%b req=%b",
                 tag, PC, Instruction, PCPlusFour, Valid, IMem_Req);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0; PCSel = 1'b0; BranchTarget = 32'h0; Stall_PC = 1'b0;
        Flush = 1'b0; IMem_Ready = 1'b1; mem_off = 32'h100;

        // Reset state
        step(); step();
        chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Streaming fetch from 0
        Reset = 1'b1;
        step(); chk_all("fetch0", 32'h100, 32'h4, 1'b1, 32'h4, 1'b1);
        step(); chk_all("fetch4", 32'h104, 32'h8, 1'b1, 32'h8, 1'b1);

        // Three memory wait cycles at PC=0x8
        IMem_Ready = 1'b0;
        step(); chk_all("wait1", 32'h0, 32'h8, 1'b0, 32'h8, 1'b1);
        step(); chk_all("wait2", 32'h0, 32'h8, 1'b0, 32'h8, 1'b1);
        step(); chk_all("wait3", 32'h0, 32'h8, 1'b0, 32'h8, 1'b1);
        IMem_Ready = 1'b1;
        step(); chk_all("fetch8", 32'h108, 32'hC, 1'b1, 32'hC, 1'b1);
        step(); chk_all("fetchC", 32'h10C, 32'h10, 1'b1, 32'h10, 1'b1);

        // Stall with memory ready at PC=0x10: park word, freeze IF/ID
        Stall_PC = 1'b1;
        step(); chk_all("hold1", 32'h10C, 32'h10, 1'b1, 32'h10, 1'b0);
        mem_off = 32'h900;  // memory now disagrees: released word must come from skid
        step(); chk_all("hold2", 32'h10C, 32'h10, 1'b1, 32'h10, 1'b0);
        Stall_PC = 1'b0;
        step(); chk_all("release", 32'h110, 32'h14, 1'b1, 32'h14, 1'b1);
        mem_off = 32'h100;

        // Stall while memory not ready: nothing moves
        Stall_PC = 1'b1; IMem_Ready = 1'b0;
        step(); chk_all("stallwait", 32'h110, 32'h14, 1'b1, 32'h14, 1'b1);
        Stall_PC = 1'b0; IMem_Ready = 1'b1;

        // Flush: word discarded, PC still advances
        Flush = 1'b1;
        step();
        chk("flush.valid", {31'd0, Valid}, 32'd0);
        chk("flush.instr", Instruction, 32'h0);
        chk("flush.pc", PC, 32'h18);
        $display("step flush        pc=%h instr=%h valid=%b", PC, Instruction, Valid);

        // Redirect beats stall and flush, low bits forced to zero
        PCSel = 1'b1; BranchTarget = 32'h203; Stall_PC = 1'b1;
        step();
        chk("br.pc", PC, 32'h200);
        chk("br.addr", IMem_Addr, 32'h200);
        chk("br.valid", {31'd0, Valid}, 32'd0);
        chk("br.instr", Instruction, 32'h0);
        $display("step branch       pc=%h addr=%h valid=%b", PC, IMem_Addr, Valid);
        PCSel = 1'b0; Stall_PC = 1'b0; Flush = 1'b0;
        step(); chk_all("fetch200", 32'h300, 32'h204, 1'b1, 32'h204, 1'b1);

        // Redirect out of HOLD drops the skid word
        Stall_PC = 1'b1;
        step(); chk_all("hold204", 32'h300, 32'h204, 1'b1, 32'h204, 1'b0);
        PCSel = 1'b1; BranchTarget = 32'h400;
        step(); chk_all("brhold", 32'h0, 32'h204, 1'b0, 32'h400, 1'b1);
        PCSel = 1'b0; Stall_PC = 1'b0;
        step(); chk_all("fetch400", 32'h500, 32'h404, 1'b1, 32'h404, 1'b1);

        // Wrap at top of address space
        PCSel = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        step(); chk_all("brtop", 32'h0, 32'h404, 1'b0, 32'hFFFF_FFFC, 1'b1);
        PCSel = 1'b0;
        step(); chk_all("wrap", 32'h0000_00FC, 32'h0, 1'b1, 32'h0, 1'b1);
        step(); chk_all("fetch0b", 32'h100, 32'h4, 1'b1, 32'h4, 1'b1);

        // Reset asserted while in HOLD
        Stall_PC = 1'b1;
        step(); chk_all("hold4", 32'h100, 32'h4, 1'b1, 32'h4, 1'b0);
        Reset = 1'b0;
        #1;
        chk_all("rsthold", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        Stall_PC = 1'b0;
        step();
        Reset = 1'b1;
        step(); chk_all("postrst", 32'h100, 32'h4, 1'b1, 32'h4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
